inference_sequencer: RTL and testbench
======================================

Name: inference_sequencer

Overview:
- Per-beat controller for the spiking ECG classifier.
- Accepts one beat request at a time and clears the network and the class decision stage.
- Steps the network one timestep per cycle until the decision stage reports end of process, or until a watchdog limit is reached.
- Returns the captured class through a valid/ready result port and keeps saturating per-class beat counts for the host.

Parameters:
- CLEAR_CYCLES, 2, cycles net_clear is held high before stepping starts (1..15).
- MAX_STEPS, 16, watchdog limit on timesteps per beat (1..255).
- STAT_W, 16, width of each per-class statistics counter.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- resetn  in  1  synchronous, active-high reset (despite the name); clears all state.
- beat_valid  in  1  host requests classification of the loaded beat.
- beat_ready  out  1  sequencer can accept a beat; high only in IDLE.
- net_clear  out  1  clears neuron state and the decision-stage timer (drives their reset).
- step_en  out  1  advances the network and decision timer by one timestep.
- end_process  in  1  decision stage: spike seen or timer expired.
- no_spike  in  1  decision stage: timer expired.
- class_in  in  2  decision-stage class; 2'b11 means none.
- res_class  out  2  captured class.
- res_timeout  out  1  no_spike was set at capture, or the watchdog fired.
- res_valid  out  1  result available.
- res_ready  in  1  host accepts result.
- stat_clr  in  1  synchronous clear of all statistics counters.
- stat_cnt0..stat_cnt3  out  STAT_W each  beats classified as class 0/1/2/3.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, CLEAR, RUN, DONE.
- Reset (resetn=1 at a clock edge):
  - State goes to IDLE.
  - beat_ready=1, busy=0, net_clear=0, step_en=0.
  - res_valid=0, res_class=0, res_timeout=0.
  - All stat_cnt = 0, and the internal clear and step counters = 0.
  - Reset mid-operation abandons the beat; no counter increments.
- IDLE:
  - beat_ready=1.
  - If beat_valid is high, the next state is CLEAR and the clear counter loads 0.
- CLEAR:
  - net_clear=1 and step_en=0 for exactly CLEAR_CYCLES consecutive cycles.
  - The next state is then RUN and the step counter loads 0.
  - beat_valid is ignored.
- RUN:
  - step_en=1 on every cycle spent in RUN.
  - end_process is sampled on each RUN cycle. If it is 1, capture res_class=class_in and res_timeout=no_spike, then go to DONE. end_process is honoured on the first RUN cycle.
  - Otherwise the step counter increments. If the incremented value equals MAX_STEPS, capture res_class=2'b11 and res_timeout=1, then go to DONE (watchdog).
  - end_process wins over the watchdog in the same cycle.
  - Maximum RUN residency is MAX_STEPS cycles.
- DONE:
  - res_valid=1, step_en=0, and res_class/res_timeout hold stable.
  - When res_ready=1, go to IDLE and res_valid drops on the next cycle. res_valid is never deasserted without res_ready.
  - res_class and res_timeout retain their values in IDLE until the next capture.
- Latency: from beat acceptance to res_valid = 1 + CLEAR_CYCLES + (number of RUN cycles) cycles.
- Statistics:
  - At the capture edge, stat_cnt[res_class] increments by 1, saturating at 2^STAT_W-1 with no wrap.
  - stat_clr zeroes all counters. It takes priority over a same-cycle increment, and the captured beat is not counted.
  - Counters are independent of the result handshake.
- step_en and net_clear are never high together.

Test Plan:
- Basic spike result: CLEAR_CYCLES=2. Accept beat; end_process=1 with class_in=01, no_spike=0 on the 3rd RUN cycle -> net_clear high for 2 cycles, step_en high for 3 cycles, res_valid with res_class=01 and res_timeout=0; stat_cnt1=1.
- Decision-timer expiry: end_process=1 with no_spike=1 and class_in=11 -> res_class=11, res_timeout=1, stat_cnt3=1.
- Watchdog: MAX_STEPS=16 and end_process held 0 -> exactly 16 step_en pulses, then res_class=11, res_timeout=1; watchdog coinciding with end_process=1 (class 10) -> res_class=10.
- Back-pressure: hold res_ready=0 for 10 cycles -> res_valid and res_class stable, beat_ready=0; beat_valid pulses are ignored; res_ready=1 -> IDLE next cycle, beat_ready=1.
- Saturation and clear:
  - STAT_W=2, five class-0 beats -> stat_cnt0=3.
  - stat_clr asserted on a capture edge -> all counters 0.
- Reset mid-RUN: resetn=1 during RUN -> next cycle IDLE, step_en=0, res_valid=0, all counters 0.

Source files
------------

// File: rtl/inference_sequencer_if.sv
// Host-side port bundle of the inference sequencer: beat request, result
// handshake, and the per-class statistics readout.
interface inference_sequencer_if #(
    parameter int unsigned STAT_W = 16
);
    logic              beat_valid;
    logic              beat_ready;
    logic [1:0]        res_class;
    logic              res_timeout;
    logic              res_valid;
    logic              res_ready;
    logic              stat_clr;
    logic [STAT_W-1:0] stat_cnt0;
    logic [STAT_W-1:0] stat_cnt1;
    logic [STAT_W-1:0] stat_cnt2;
    logic [STAT_W-1:0] stat_cnt3;
    logic              busy;

    modport master (
        output beat_valid, res_ready, stat_clr,
        input  beat_ready, res_class, res_timeout, res_valid,
        input  stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3, busy
    );

    modport slave (
        input  beat_valid, res_ready, stat_clr,
        output beat_ready, res_class, res_timeout, res_valid,
        output stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3, busy
    );
endinterface

// File: rtl/inference_sequencer.sv
// Per-beat controller for the spiking ECG classifier: clears the network,
// steps it until the decision stage ends or the watchdog fires, returns the class.
module inference_sequencer #(
    parameter int unsigned CLEAR_CYCLES = 2,
    parameter int unsigned MAX_STEPS    = 16,
    parameter int unsigned STAT_W       = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    inference_sequencer_if.slave  host,
    output logic                  net_clear,
    output logic                  step_en,
    input  logic                  end_process,
    input  logic                  no_spike,
    input  logic [1:0]            class_in
);
    localparam int unsigned CLR_W  = 4;
    localparam int unsigned STEP_W = 8;
    localparam int unsigned NCLS   = 4;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
    logic [STEP_W-1:0]  step_inc;
    logic [1:0]         res_class_q, res_class_d;
    logic               res_timeout_q, res_timeout_d;
    logic               capture;
    logic               beat_ready_q, busy_q, net_clear_q, step_en_q, res_valid_q;
    logic [STAT_W-1:0]  stat_q [NCLS];

    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        step_cnt_d    = step_cnt_q;
        res_class_d   = res_class_q;
        res_timeout_d = res_timeout_q;
        capture       = 1'b0;
        step_inc      = step_cnt_q + STEP_W'(1);
        case (state_q)
            IDLE: begin
                if (host.beat_valid) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_d    = RUN;
                    step_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            RUN: begin
                // A decision in the same cycle as the watchdog takes precedence.
                if (end_process) begin
                    capture       = 1'b1;
                    res_class_d   = class_in;
                    res_timeout_d = no_spike;
                    state_d       = DONE;
                end else begin
                    step_cnt_d = step_inc;
                    if (step_inc == STEP_W'(MAX_STEPS)) begin
                        capture       = 1'b1;
                        res_class_d   = 2'b11;
                        res_timeout_d = 1'b1;
                        state_d       = DONE;
                    end
                end
            end
            DONE: begin
                if (host.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and Moore outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q       <= IDLE;
            clr_cnt_q     <= '0;
            step_cnt_q    <= '0;
            res_class_q   <= '0;
            res_timeout_q <= 1'b0;
            beat_ready_q  <= 1'b1;
            busy_q        <= 1'b0;
            net_clear_q   <= 1'b0;
            step_en_q     <= 1'b0;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            step_cnt_q    <= step_cnt_d;
            res_class_q   <= res_class_d;
            res_timeout_q <= res_timeout_d;
            beat_ready_q  <= (state_d == IDLE);
            busy_q        <= (state_d != IDLE);
            net_clear_q   <= (state_d == CLEAR);
            step_en_q     <= (state_d == RUN);
            res_valid_q   <= (state_d == DONE);
        end
    end

    // Saturating per-class beat counts; a clear drops a same-cycle capture.
    always_ff @(posedge clk) begin
        if (resetn || host.stat_clr) begin
            for (int i = 0; i < NCLS; i++) stat_q[i] <= '0;
        end else if (capture && (stat_q[res_class_d] != '1)) begin
            stat_q[res_class_d] <= stat_q[res_class_d] + STAT_W'(1);
        end
    end

    assign net_clear        = net_clear_q;
    assign step_en          = step_en_q;
    assign host.beat_ready  = beat_ready_q;
    assign host.busy        = busy_q;
    assign host.res_valid   = res_valid_q;
    assign host.res_class   = res_class_q;
    assign host.res_timeout = res_timeout_q;
    assign host.stat_cnt0   = stat_q[0];
    assign host.stat_cnt1   = stat_q[1];
    assign host.stat_cnt2   = stat_q[2];
    assign host.stat_cnt3   = stat_q[3];
endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: table of beats plus hand-written
// back-pressure, clear-on-capture and mid-run reset sequences.
module tb_inference_sequencer;
    localparam int unsigned CLEAR_CYCLES = 2;
    localparam int unsigned MAX_STEPS    = 16;
    localparam int unsigned STAT_W       = 2;
    localparam int          STAT_MAX     = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       net_clear, step_en;
    logic       end_process, no_spike;
    logic [1:0] class_in;

    int checks   = 0;
    int failures = 0;
    int exp_stat [4];

    inference_sequencer_if #(.STAT_W(STAT_W)) hif ();

    inference_sequencer #(
        .CLEAR_CYCLES(CLEAR_CYCLES),
        .MAX_STEPS   (MAX_STEPS),
        .STAT_W      (STAT_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .host       (hif.slave),
        .net_clear  (net_clear),
        .step_en    (step_en),
        .end_process(end_process),
        .no_spike   (no_spike),
        .class_in   (class_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         end_cyc;
        logic [1:0] cls;
        logic       ns;
        logic [1:0] ecls;
        logic       eto;
        int         esteps;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] stat_of(input int i);
        case (i)
            0:       return 32'(hif.stat_cnt0);
            1:       return 32'(hif.stat_cnt1);
            2:       return 32'(hif.stat_cnt2);
            default: return 32'(hif.stat_cnt3);
        endcase
    endfunction

    task automatic chk_stats(input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_stat%0d", tag, i), stat_of(i), 32'(exp_stat[i]));
    endtask

    // Runs one beat; end_process is raised on RUN cycle end_cyc (0 = never).
    task automatic run_beat(input int end_cyc, input logic [1:0] cls, input logic ns,
                            input logic [1:0] ecls, input logic eto, input int esteps,
                            input bit clr_cap, input bit ack);
        int  lat, nclr, nstep;
        bit  done;
        lat = 0; nclr = 0; nstep = 0; done = 0;
        @(negedge clk);
        chk("idle_beat_ready", 32'(hif.beat_ready), 32'd1);
        hif.beat_valid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            hif.beat_valid = 1'b0;
            lat++;
            if (hif.res_valid) begin
                done = 1;
            end else begin
                chk("no_overlap", 32'(net_clear & step_en), 32'd0);
                if (net_clear) nclr++;
                if (step_en) begin
                    nstep++;
                    class_in = cls;
                    no_spike = ns;
                    end_process  = (nstep == end_cyc);
                    hif.stat_clr = clr_cap && (nstep == end_cyc);
                end
            end
        end
        end_process  = 1'b0;
        hif.stat_clr = 1'b0;
        chk("res_valid_seen", 32'(done), 32'd1);
        chk("latency", 32'(lat), 32'(1 + CLEAR_CYCLES + esteps));
        chk("clear_cycles", 32'(nclr), 32'(CLEAR_CYCLES));
        chk("step_pulses", 32'(nstep), 32'(esteps));
        chk("res_class", 32'(hif.res_class), 32'(ecls));
        chk("res_timeout", 32'(hif.res_timeout), 32'(eto));
        chk("done_busy", 32'(hif.busy), 32'd1);
        chk("done_step_en", 32'(step_en), 32'd0);
        if (clr_cap) begin
            for (int i = 0; i < 4; i++) exp_stat[i] = 0;
        end else if (exp_stat[ecls] < STAT_MAX) begin
            exp_stat[ecls]++;
        end
        chk_stats("beat");
        if (ack) begin
            hif.res_ready = 1'b1;
            @(negedge clk);
            hif.res_ready = 1'b0;
            chk("ack_res_valid", 32'(hif.res_valid), 32'd0);
            chk("ack_beat_ready", 32'(hif.beat_ready), 32'd1);
            chk("ack_busy", 32'(hif.busy), 32'd0);
            chk("idle_res_class_hold", 32'(hif.res_class), 32'(ecls));
            chk("idle_res_timeout_hold", 32'(hif.res_timeout), 32'(eto));
        end
    endtask

    initial begin
        vecs[0] = '{3,  2'b01, 1'b0, 2'b01, 1'b0, 3};
        vecs[1] = '{5,  2'b11, 1'b1, 2'b11, 1'b1, 5};
        vecs[2] = '{0,  2'b01, 1'b0, 2'b11, 1'b1, 16};
        vecs[3] = '{16, 2'b10, 1'b0, 2'b10, 1'b0, 16};
        vecs[4] = '{1,  2'b00, 1'b0, 2'b00, 1'b0, 1};
        vecs[5] = '{2,  2'b10, 1'b1, 2'b10, 1'b1, 2};
        vecs[6] = '{2,  2'b00, 1'b0, 2'b00, 1'b0, 2};
        vecs[7] = '{4,  2'b00, 1'b0, 2'b00, 1'b0, 4};
        vecs[8] = '{7,  2'b00, 1'b0, 2'b00, 1'b0, 7};
        vecs[9] = '{1,  2'b00, 1'b1, 2'b00, 1'b1, 1};

        for (int i = 0; i < 4; i++) exp_stat[i] = 0;
        resetn         = 1'b1;
        hif.beat_valid = 1'b0;
        hif.res_ready  = 1'b0;
        hif.stat_clr   = 1'b0;
        end_process    = 1'b0;
        no_spike       = 1'b0;
        class_in       = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_beat_ready", 32'(hif.beat_ready), 32'd1);
        chk("rst_busy", 32'(hif.busy), 32'd0);
        chk("rst_net_clear", 32'(net_clear), 32'd0);
        chk("rst_step_en", 32'(step_en), 32'd0);
        chk("rst_res_valid", 32'(hif.res_valid), 32'd0);
        chk("rst_res_class", 32'(hif.res_class), 32'd0);
        chk("rst_res_timeout", 32'(hif.res_timeout), 32'd0);
        chk_stats("rst");
        resetn = 1'b0;

        for (int v = 0; v < 10; v++)
            run_beat(vecs[v].end_cyc, vecs[v].cls, vecs[v].ns,
                     vecs[v].ecls, vecs[v].eto, vecs[v].esteps, 1'b0, 1'b1);

        // Back-pressure: result held, new beat requests ignored.
        run_beat(2, 2'b01, 1'b0, 2'b01, 1'b0, 2, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            hif.beat_valid = k[0];
            @(negedge clk);
            chk("bp_res_valid", 32'(hif.res_valid), 32'd1);
            chk("bp_res_class", 32'(hif.res_class), 32'd1);
            chk("bp_beat_ready", 32'(hif.beat_ready), 32'd0);
            chk("bp_step_en", 32'(step_en), 32'd0);
        end
        hif.beat_valid = 1'b0;
        hif.res_ready  = 1'b1;
        @(negedge clk);
        hif.res_ready = 1'b0;
        chk("bp_release_valid", 32'(hif.res_valid), 32'd0);
        chk("bp_release_ready", 32'(hif.beat_ready), 32'd1);
        @(negedge clk);
        chk("bp_no_restart", 32'(hif.busy), 32'd0);

        // Clear coinciding with a capture: nothing counted.
        run_beat(3, 2'b10, 1'b0, 2'b10, 1'b0, 3, 1'b1, 1'b1);

        // Count one beat, then reset in the middle of RUN.
        run_beat(1, 2'b10, 1'b0, 2'b10, 1'b0, 1, 1'b0, 1'b1);
        hif.beat_valid = 1'b1;
        @(negedge clk);
        hif.beat_valid = 1'b0;
        repeat (CLEAR_CYCLES + 2) @(negedge clk);
        chk("pre_rst_step_en", 32'(step_en), 32'd1);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) exp_stat[i] = 0;
        chk("midrst_step_en", 32'(step_en), 32'd0);
        chk("midrst_res_valid", 32'(hif.res_valid), 32'd0);
        chk("midrst_beat_ready", 32'(hif.beat_ready), 32'd1);
        chk("midrst_busy", 32'(hif.busy), 32'd0);
        chk("midrst_res_class", 32'(hif.res_class), 32'd0);
        chk_stats("midrst");
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(hif.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
